// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer with a one-entry holding register per channel.
// Define STREAM_DEMUX_CNT_EN to build the per-channel delivered-word counters.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t st0;
  ch_state_t st1;
  logic      load0;
  logic      load1;
  logic      take0;
  logic      take1;

  // Acceptance looks only at the selected channel, so a stalled channel never blocks the other.
  always_comb begin
    in_ready = in_sel ? ((st1 == EMPTY) || out1_ready)
                      : ((st0 == EMPTY) || out0_ready);
    load0    = in_valid && in_ready && !in_sel;
    load1    = in_valid && in_ready &&  in_sel;
    take0    = (st0 == FULL) && out0_ready;
    take1    = (st1 == FULL) && out1_ready;
  end

  assign out0_valid = (st0 == FULL);
  assign out1_valid = (st1 == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0       <= EMPTY;
      st1       <= EMPTY;
      out0_data <= '0;
      out1_data <= '0;
    end else begin
      case (st0)
        EMPTY: begin
          if (load0) begin
            st0       <= FULL;
            out0_data <= in_data;
          end
        end
        FULL: begin
          // A load while FULL implies out0_ready, i.e. a pass-through.
          if (load0) begin
            out0_data <= in_data;
          end else if (out0_ready) begin
            st0 <= EMPTY;
          end
        end
        default: st0 <= EMPTY;
      endcase

      case (st1)
        EMPTY: begin
          if (load1) begin
            st1       <= FULL;
            out1_data <= in_data;
          end
        end
        FULL: begin
          if (load1) begin
            out1_data <= in_data;
          end else if (out1_ready) begin
            st1 <= EMPTY;
          end
        end
        default: st1 <= EMPTY;
      endcase
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (take0) cnt0_q <= cnt0_q + 1'b1;
      if (take1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  logic unused_take;
  assign unused_take = take0 ^ take1;
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus randomized traffic vs a queue model.
module tb_stream_demux;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

`ifdef STREAM_DEMUX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int total = 0;
  int bad   = 0;

  stream_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    logic [CNT_W-1:0] v;
    v = n[CNT_W-1:0];
    return CNT_ON ? v : '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if ({out0_valid, out1_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", {out0_valid, out1_valid}); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out0_valid !== 1'b1 || out0_data !== 8'h5A) begin bad++; $display("FAIL rst_load0 got=%b/%h exp=1/5a", out0_valid, out0_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out0_valid !== 1'b0 || out0_data !== 8'h00 || out1_data !== 8'h00) begin
      bad++; $display("FAIL rst_async got=%b/%h/%h exp=0/00/00", out0_valid, out0_data, out1_data);
    end
    total++; if (cnt0 !== '0 || cnt1 !== '0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out1_valid !== 1'b1 || out1_data !== 8'h11 || out0_valid !== 1'b0) begin
      bad++; $display("FAIL rst_after got=%b/%h/%b exp=1/11/0", out1_valid, out1_data, out0_valid);
    end
  endtask

  task automatic test_steering();
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL steer_rdy0 got=%b exp=1", in_ready); end
    @(negedge clk);
    in_sel = 1'b1; in_data = 8'hB2;
    #1;
    total++; if (in_ready !== 1'b1 || out0_valid !== 1'b1 || out0_data !== 8'hA1) begin
      bad++; $display("FAIL steer_a1 got=%b/%b/%h exp=1/1/a1", in_ready, out0_valid, out0_data);
    end
    @(negedge clk);
    in_sel = 1'b0; in_data = 8'hC3;
    #1;
    total++; if (in_ready !== 1'b1 || out1_valid !== 1'b1 || out1_data !== 8'hB2 || out0_valid !== 1'b0) begin
      bad++; $display("FAIL steer_b2 got=%b/%b/%h/%b exp=1/1/b2/0", in_ready, out1_valid, out1_data, out0_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out0_valid !== 1'b1 || out0_data !== 8'hC3 || out1_valid !== 1'b0) begin
      bad++; $display("FAIL steer_c3 got=%b/%h/%b exp=1/c3/0", out0_valid, out0_data, out1_valid);
    end
    @(negedge clk);
    #1;
    total++; if (cnt0 !== exp_cnt(2) || cnt1 !== exp_cnt(1)) begin
      bad++; $display("FAIL steer_cnt got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, exp_cnt(2), exp_cnt(1));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33;
    @(negedge clk);
    in_data = 8'h55;
    #1;
    total++; if (in_ready !== 1'b0 || out0_data !== 8'h33 || out0_valid !== 1'b1) begin
      bad++; $display("FAIL bp_block got=%b/%h/%b exp=0/33/1", in_ready, out0_data, out0_valid);
    end
    @(negedge clk);
    in_sel = 1'b1; in_data = 8'h44;
    #1;
    total++; if (in_ready !== 1'b1 || out0_data !== 8'h33) begin
      bad++; $display("FAIL bp_other got=%b/%h exp=1/33", in_ready, out0_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out1_valid !== 1'b1 || out1_data !== 8'h44 || out0_valid !== 1'b1 || out0_data !== 8'h33) begin
      bad++; $display("FAIL bp_hold got=%b/%h/%b/%h exp=1/44/1/33", out1_valid, out1_data, out0_valid, out0_data);
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h01;
    @(negedge clk);
    out1_ready = 1'b1; in_data = 8'h02;
    #1;
    total++; if (in_ready !== 1'b1 || out1_data !== 8'h01) begin
      bad++; $display("FAIL pt_rdy got=%b/%h exp=1/01", in_ready, out1_data);
    end
    @(negedge clk);
    in_valid = 1'b0; out1_ready = 1'b0;
    #1;
    total++; if (out1_valid !== 1'b1 || out1_data !== 8'h02 || cnt1 !== exp_cnt(1)) begin
      bad++; $display("FAIL pt_next got=%b/%h/%0d exp=1/02/%0d", out1_valid, out1_data, cnt1, exp_cnt(1));
    end
  endtask

  task automatic test_counter_wrap();
    int stalls = 0;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'($urandom);
      #1;
      if (in_ready !== 1'b1) stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (stalls != 0) begin bad++; $display("FAIL wrap_stall got=%0d exp=0", stalls); end
    total++; if (cnt0 !== exp_cnt(257) || cnt1 !== exp_cnt(0)) begin
      bad++; $display("FAIL wrap_cnt got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, exp_cnt(257), exp_cnt(0));
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int n0 = 0;
    int n1 = 0;
    bit exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom);
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
      total++; if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", cyc, out0_valid, out1_valid, q0.size() != 0, q1.size() != 0);
      end
      if (q0.size() != 0) begin
        total++; if (out0_data !== q0[0]) begin bad++; $display("FAIL rnd_d0 cyc=%0d got=%h exp=%h", cyc, out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        total++; if (out1_data !== q1[0]) begin bad++; $display("FAIL rnd_d1 cyc=%0d got=%h exp=%h", cyc, out1_data, q1[0]); end
      end
      total++; if (cnt0 !== exp_cnt(n0) || cnt1 !== exp_cnt(n1)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, cnt0, cnt1, exp_cnt(n0), exp_cnt(n1));
      end
      @(posedge clk);
      if (q0.size() != 0 && out0_ready) begin void'(q0.pop_front()); n0++; end
      if (q1.size() != 0 && out1_ready) begin void'(q1.pop_front()); n1++; end
      if (in_valid && exp_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    test_reset();
    test_steering();
    test_backpressure();
    test_passthrough();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on the input and on both outputs. It is the distribution-side counterpart of the 2:1 select mux used in the barrel-shifter datapath. It steers each accepted input word to output channel 0 or 1 according to a per-word select bit. Each channel has its own one-entry holding register, so a stalled channel never blocks traffic bound for the other.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `CNT_W`, 8, width of the per-channel transfer counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in WIDTH: input word.
- `in_sel` in 1: destination of `in_data`; 0 selects channel 0, 1 selects channel 1.
- `in_valid` in 1: `in_data` and `in_sel` are valid.
- `in_ready` out 1: the block accepts the word this cycle.
- `out0_data` out WIDTH: channel 0 word.
- `out0_valid` out 1: channel 0 holds a word.
- `out0_ready` in 1: channel 0 consumer takes the word.
- `out1_data` out WIDTH: channel 1 word.
- `out1_valid` out 1: channel 1 holds a word.
- `out1_ready` in 1: channel 1 consumer takes the word.
- `cnt0` out CNT_W: number of words delivered on channel 0.
- `cnt1` out CNT_W: number of words delivered on channel 1.

## Operation
- Each channel k has a two-state machine.
  - EMPTY: `outk_valid`=0.
  - FULL: `outk_valid`=1, and `outk_data` holds the stored word.
- The stored word remains stable while FULL and `outk_ready`=0.
- Acceptance:
  - `in_ready` = (selected channel EMPTY) OR (selected channel FULL AND `out_sel_ready`=1).
  - `in_ready` is combinational on `in_sel`, the channel state and the selected channel's `out_ready`.
  - It does not depend on `in_valid`.
- A transfer occurs on a rising edge with `in_valid`=1 and `in_ready`=1.
- Channel transitions:
  - EMPTY → FULL: on a transfer with `in_sel`=k; `outk_data` ← `in_data`.
  - FULL → EMPTY: when `outk_ready`=1 and there is no transfer to k.
  - FULL → FULL with new data: when `outk_ready`=1 and there is a transfer to k in the same cycle (pass-through).
  - FULL and `outk_ready`=0: the channel holds, and `in_ready`=0 whenever `in_sel`=k.
- Channels are independent. In the same cycle:
  - a word may drain from channel 0,
  - a word may drain from channel 1,
  - and the input may load either channel.
- Each word is delivered exactly once, in input order within a channel. There is no ordering guarantee between channels.
- `outk_valid` never depends combinationally on any input.
- Counters: `cntk` increments by 1 on each cycle with `outk_valid`=1 and `outk_ready`=1. The count wraps modulo 2^CNT_W.

## Timing
- Reset (asserted asynchronously, immediately):
  - `out0_valid`=`out1_valid`=0
  - `out0_data`=`out1_data`=0
  - `cnt0`=`cnt1`=0
  - both channels EMPTY
- While `rst_n`=0, `in_ready` reads 1, because the selected channel is EMPTY. No transfer is recorded.
- Reset mid-operation: held words are discarded without delivery and counters clear. After deassertion, the first edge behaves as from power-up.
- Latency: a word accepted at edge N appears on `outk_data` with `outk_valid`=1 after edge N. It is consumable at edge N+1.
- Throughput: one word per cycle per channel while `outk_ready`=1. Alternating `in_sel` also sustains one word per cycle.
- Counter update is visible the cycle after the handshake.

## Configuration
- Macro: `STREAM_DEMUX_CNT_EN`.
- Defined: `cnt0`/`cnt1` are implemented as described.
- Undefined: the counter registers are not built, and `cnt0`/`cnt1` are tied to constant 0. All other behaviour is identical.

## Test plan
- Reset: drive `rst_n`=0 mid-stream with channel 0 FULL (0x5A).
  - Response: `out0_valid` drops at once; outputs and counters read 0.
  - After release, send 0x11 to channel 1; it appears one cycle later.
- Steering: with both readies=1, send 0xA1 (sel 0), 0xB2 (sel 1), 0xC3 (sel 0) back-to-back.
  - Response: `out0` shows 0xA1 then 0xC3; `out1` shows 0xB2.
  - `in_ready` stays 1; `cnt0`=2 and `cnt1`=1 (with the macro defined).
- Backpressure isolation: hold `out0_ready`=0 with channel 0 FULL (0x33).
  - Sending to channel 0: `in_ready`=0, and 0x33 is held stable.
  - Sending 0x44 to channel 1: accepted immediately.
- Pass-through: channel 1 FULL (0x01), `out1_ready`=1, input 0x02 with sel 1 in the same cycle.
  - Response: `in_ready`=1, 0x01 is consumed, and `out1_data`=0x02 next cycle with `out1_valid` still 1.
- Counter wrap (macro defined, CNT_W=8): deliver 257 words on channel 0.
  - Response: `cnt0`=1, `cnt1`=0.
- Build without `STREAM_DEMUX_CNT_EN`, rerun the steering scenario.
  - Response: identical data and handshakes; `cnt0`=`cnt1`=0 throughout.
